// File: rtl/cell_probe_pkg.sv
// Shared types and constants for the two-input cell prober.
// Holds the sequencer state encoding and the truth tables for common cells.
package cell_probe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   // Truth tables are indexed by {A,B}: bit 0 is A=0,B=0.
   localparam logic [3:0] TRUTH_NOR   = 4'b0001;
   localparam logic [3:0] TRUTH_NAND  = 4'b0111;
   localparam logic [3:0] TRUTH_INV_A = 4'b0011;

   function automatic logic truth_lookup(input logic [3:0] truth, input logic [1:0] vec);
      return truth[vec];
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
// Latency two clk cycles; no flow control.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cell_probe.sv
// Sweeps the four {A,B} vectors into a cell, compares synchronized Y to a latched truth table.
// Run length PASSES*4*(SETTLE_CYCLES+2) cycles; start ignored while busy. CELL_PROBE_CAPTURE_EN enables fail_vec.
module cell_probe
   import cell_probe_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned PASSES        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] truth,
   output logic       drive_a,
   output logic       drive_b,
   input  logic       sense_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [2:0] fail_vec
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] vec;
   logic [3:0] pass_cnt;
   logic [7:0] settle_cnt;
   logic [3:0] truth_q;
   logic       y_sync;
   logic       mismatch;
   logic [7:0] err_nxt;

   sync2 u_sync_y (
      .clk (clk),
      .rst (rst),
      .d   (sense_y),
      .q   (y_sync)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = DRIVE;
         end
         DRIVE: begin
            busy      = 1'b1;
            state_nxt = SETTLE;
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            busy = 1'b1;
            if (vec == 2'd3 && pass_cnt == PASS_LAST) state_nxt = DONE;
            else                                      state_nxt = DRIVE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      drive_a = busy & vec[1];
      drive_b = busy & vec[0];
   end

   // The count saturates rather than wrapping so a badly broken cell never reads as passing.
   always_comb begin
      mismatch = (state == SAMPLE) && (y_sync != truth_lookup(truth_q, vec));
      err_nxt  = err_count;
      if (mismatch && err_count != 8'hFF) err_nxt = err_count + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= 2'd0;
         pass_cnt   <= 4'd0;
         settle_cnt <= 8'd0;
         truth_q    <= 4'd0;
         err_count  <= 8'd0;
         pass       <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  truth_q   <= truth;
                  err_count <= 8'd0;
                  pass      <= 1'b0;
                  vec       <= 2'd0;
                  pass_cnt  <= 4'd0;
               end
            end
            DRIVE:  settle_cnt <= 8'd0;
            SETTLE: settle_cnt <= settle_cnt + 8'd1;
            SAMPLE: begin
               err_count <= err_nxt;
               vec       <= vec + 2'd1;
               if (vec == 2'd3) pass_cnt <= pass_cnt + 4'd1;
               if (state_nxt == DONE) pass <= (err_nxt == 8'd0);
            end
            default: ;
         endcase
      end
   end

`ifdef CELL_PROBE_CAPTURE_EN
   logic [2:0] fail_vec_q;

   // Bit 2 doubles as the "already captured" flag so only the first mismatch is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         fail_vec_q <= 3'b000;
      end else if (state == IDLE && start) begin
         fail_vec_q <= 3'b000;
      end else if (mismatch && !fail_vec_q[2]) begin
         fail_vec_q <= {1'b1, vec};
      end
   end

   assign fail_vec = fail_vec_q;
`else
   assign fail_vec = 3'b000;
`endif

endmodule

// File: tb/tb_cell_probe.sv
// Bench for cell_probe: four parameterisations driven by behavioural cell models,
// results compared with an independent per-vector expectation.
`timescale 1ns/1ps
module tb_cell_probe;
   import cell_probe_pkg::*;

   localparam int NDUT  = 4;
   localparam int HN    = 8192;
   localparam int M_NOR = 0;
   localparam int M_ST0 = 1;
   localparam int M_ST1 = 2;
   localparam int M_DLY = 3;
   localparam int M_RND = 4;

   function automatic int s_of(input int k);
      case (k)
         2:       return 2;
         3:       return 6;
         default: return 4;
      endcase
   endfunction

   function automatic int p_of(input int k);
      return (k == 1) ? 15 : 1;
   endfunction

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s   [NDUT];
   logic [3:0] truth_s   [NDUT];
   logic       sense_s   [NDUT];
   logic       drive_a_s [NDUT];
   logic       drive_b_s [NDUT];
   logic       busy_s    [NDUT];
   logic       done_s    [NDUT];
   logic       pass_s    [NDUT];
   logic [7:0] err_s     [NDUT];
   logic [2:0] fail_s    [NDUT];
   int         mode      [NDUT];
   bit         y_h [NDUT][HN];
   bit         a_h [NDUT][HN];
   bit         b_h [NDUT][HN];
   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      cell_probe #(
         .SETTLE_CYCLES (s_of(k)),
         .PASSES        (p_of(k))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_s[k]),
         .truth     (truth_s[k]),
         .drive_a   (drive_a_s[k]),
         .drive_b   (drive_b_s[k]),
         .sense_y   (sense_s[k]),
         .busy      (busy_s[k]),
         .done      (done_s[k]),
         .pass      (pass_s[k]),
         .err_count (err_s[k]),
         .fail_vec  (fail_s[k])
      );
   end

   // Cell models: Y is updated once per cycle at the falling edge and logged per cycle.
   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         int c;
         bit y, da, db;
         c = cyc % HN;
         a_h[k][c] = drive_a_s[k];
         b_h[k][c] = drive_b_s[k];
         da = 1'b0;
         db = 1'b0;
         if (cyc >= 3) begin
            da = a_h[k][(cyc - 3) % HN];
            db = b_h[k][(cyc - 3) % HN];
         end
         case (mode[k])
            M_NOR:   y = !(drive_a_s[k] || drive_b_s[k]);
            M_ST0:   y = 1'b0;
            M_ST1:   y = 1'b1;
            M_DLY:   y = !(da || db);
            default: y = 1'($urandom_range(0, 1));
         endcase
         sense_s[k] = y;
         y_h[k][c]  = y;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete run on instance k; the expectation reads Y as it stood two cycles
   // before each sample, which is what a two-flop synchronizer presents.
   task automatic do_run(input int k, input logic [3:0] tr, input int md, input bit spam,
                         output int got_err, output int got_pass);
      int s, p, len, base, errs, badcyc;
      logic [2:0] want_fail;
      s = s_of(k);
      p = p_of(k);
      len = p * 4 * (s + 2);
      mode[k] = md;
      @(negedge clk);
      truth_s[k] = tr;
      start_s[k] = 1'b1;
      @(negedge clk);
      base = cyc;
      badcyc = 0;
      for (int i = 0; i < len; i++) begin
         int v;
         v = (i / (s + 2)) % 4;
         if (busy_s[k] !== 1'b1 || done_s[k] !== 1'b0 ||
             drive_a_s[k] !== v[1] || drive_b_s[k] !== v[0]) badcyc++;
         start_s[k] = spam;
         if (spam) truth_s[k] = 4'($urandom);
         @(negedge clk);
      end
      start_s[k] = 1'b0;
      errs = 0;
      want_fail = 3'b000;
      for (int pp = 0; pp < p; pp++) begin
         for (int v = 0; v < 4; v++) begin
            bit y;
            y = y_h[k][(base + (pp * 4 + v) * (s + 2) + s - 1) % HN];
            if (y != tr[v]) begin
               if (errs < 255) errs++;
               if (!want_fail[2]) want_fail = {1'b1, 2'(v)};
            end
         end
      end
`ifndef CELL_PROBE_CAPTURE_EN
      want_fail = 3'b000;
`endif
      chk("busy_drive_seq", badcyc, 0);
      chk("busy_low_at_done", busy_s[k], 0);
      chk("done_pulse", done_s[k], 1);
      chk("drive_zero_at_done", {drive_a_s[k], drive_b_s[k]}, 0);
      chk("err_count", err_s[k], errs);
      chk("pass", pass_s[k], (errs == 0) ? 1 : 0);
      chk("fail_vec", fail_s[k], want_fail);
      got_err  = err_s[k];
      got_pass = pass_s[k];
      @(negedge clk);
      chk("done_one_cycle", done_s[k], 0);
      truth_s[k] = ~tr;
      repeat (3) @(negedge clk);
      chk("idle_busy", busy_s[k], 0);
      chk("hold_result", {pass_s[k], err_s[k], fail_s[k]}, {(errs == 0) ? 1'b1 : 1'b0, 8'(errs), want_fail});
   endtask

   initial begin
      int e, ps, base, nd;
      for (int k = 0; k < NDUT; k++) begin
         start_s[k] = 1'b0;
         truth_s[k] = 4'd0;
         sense_s[k] = 1'b0;
         mode[k]    = M_NOR;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_busy", busy_s[k], 0);
         chk("rst_done", done_s[k], 0);
         chk("rst_drive", {drive_a_s[k], drive_b_s[k]}, 0);
         chk("rst_result", {pass_s[k], err_s[k], fail_s[k]}, 0);
      end
      rst = 1'b0;
      @(negedge clk);

      do_run(0, TRUTH_NOR, M_NOR, 1'b0, e, ps);
      chk("ideal_nor_err", e, 0);
      chk("ideal_nor_pass", ps, 1);

      do_run(0, TRUTH_NOR, M_ST0, 1'b0, e, ps);
      chk("stuck0_err", e, 1);

      do_run(1, TRUTH_NOR, M_ST1, 1'b0, e, ps);
      chk("stuck1_15pass_err", e, 45);
      chk("stuck1_15pass_pass", ps, 0);

      do_run(2, TRUTH_NOR, M_DLY, 1'b0, e, ps);
      chk("slow_cell_short_settle_caught", (e != 0) ? 1 : 0, 1);
      do_run(3, TRUTH_NOR, M_DLY, 1'b0, e, ps);
      chk("slow_cell_long_settle_pass", ps, 1);

      // Reset while vector 10 is settling.
      mode[0] = M_NOR;
      @(negedge clk);
      truth_s[0] = TRUTH_NOR;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      base = cyc;
      repeat (14) @(negedge clk);
      chk("pre_rst_vec10", {busy_s[0], drive_a_s[0], drive_b_s[0]}, 3'b110);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_idle", {busy_s[0], done_s[0], drive_a_s[0], drive_b_s[0]}, 0);
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_s[0] !== 1'b0) nd++;
      end
      chk("no_done_after_rst", nd, 0);
      do_run(0, TRUTH_NOR, M_NOR, 1'b0, e, ps);
      chk("rerun_after_rst_pass", ps, 1);

      // Start held high and truth scrambled throughout; NAND truth against a NOR cell.
      do_run(0, TRUTH_NAND, M_NOR, 1'b1, e, ps);
      chk("spam_latched_truth_err", e, 2);

      for (int n = 0; n < 20; n++) begin
         int k;
         case ($urandom_range(0, 3))
            0:       k = 0;
            1:       k = 2;
            2:       k = 3;
            default: k = (n % 5 == 0) ? 1 : 0;
         endcase
         do_run(k, 4'($urandom), int'($urandom_range(M_NOR, M_RND)), 1'($urandom_range(0, 1)), e, ps);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cell_probe.md
CELL_PROBE -- requirements
Module: cell_probe

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles waited after each input change before sampling; legal range 2..255.
REQ-002 Parameter PASSES, default 1: number of full 4-vector sweeps per run; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  run request; honoured only in IDLE.
REQ-006 Port truth  input  4  expected output per vector, bit index {A,B}; NOR = 4'b0001.
REQ-007 Port drive_a  output  1  drives cell pin A.
REQ-008 Port drive_b  output  1  drives cell pin B.
REQ-009 Port sense_y  input  1  cell pin Y, asynchronous to clk.
REQ-010 Port busy  output  1  high while a run is in progress.
REQ-011 Port done  output  1  one-cycle pulse at run completion.
REQ-012 Port pass  output  1  result of last run; 1 when err_count is zero.
REQ-013 Port err_count  output  8  mismatches in last run, saturating at 255.
REQ-014 Port fail_vec  output  3  first failing vector {valid,A,B} (see REQ-031).

Function
REQ-015 sense_y SHALL pass through a 2-flop synchronizer before any comparison.
REQ-016 FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE -> DRIVE when start=1; truth SHALL be latched on that edge; err_count cleared, pass cleared, vector and pass counters zeroed.
REQ-018 DRIVE (1 cycle): drive_a/drive_b SHALL present the current vector {A,B} in order 00, 01, 10, 11; -> SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles with drive pins held; -> SAMPLE.
REQ-020 SAMPLE (1 cycle): synchronized Y compared with latched truth[{A,B}]; mismatch increments err_count unless it is 255.
REQ-021 After SAMPLE: next vector -> DRIVE; after vector 11 with passes remaining -> DRIVE with vector 00; after final pass -> DONE.
REQ-022 DONE (1 cycle): done=1, pass=(err_count==0) with final count included; -> IDLE.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE, SAMPLE; 0 in IDLE and DONE.
REQ-024 Run duration: busy high for exactly PASSES*4*(SETTLE_CYCLES+2) cycles; done asserts on the cycle after busy falls.
REQ-025 start while busy or in DONE SHALL be ignored and not queued.
REQ-026 Changes on truth after the start edge SHALL have no effect on the current run.
REQ-027 drive_a, drive_b SHALL be 0 in IDLE and DONE.
REQ-028 pass, err_count, fail_vec SHALL hold their values from DONE until the next accepted start.

Reset
REQ-029 rst SHALL force IDLE on the next edge, including mid-run, with no done pulse.
REQ-030 Reset values: drive_a=0, drive_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, synchronizer flops=0.

Configuration
REQ-031 Macro CELL_PROBE_CAPTURE_EN defined: fail_vec records {1,A,B} of the first mismatch in the run and is cleared at start; undefined: fail_vec is constant 0 and no capture logic exists.

Structure
REQ-032 Shared package cell_probe_pkg SHALL hold the FSM state enum and the truth constants TRUTH_NOR=4'b0001, TRUTH_NAND=4'b0111, TRUTH_INV_A=4'b0011.
REQ-033 Sub-module sync2 (2-flop synchronizer, reset to 0) SHALL be instantiated for sense_y; all remaining logic lives in cell_probe.

Verification
REQ-034 Ideal NOR model on pins, truth=4'b0001, defaults -> busy 24 cycles, done pulse, pass=1, err_count=0, fail_vec=0.
REQ-035 Y stuck at 0, truth=4'b0001, CAPTURE_EN defined -> err_count=1, pass=0, fail_vec=3'b100.
REQ-036 Y stuck at 1, PASSES=15, truth=4'b0001 -> err_count=45, pass=0; with CAPTURE_EN fail_vec=3'b101.
REQ-037 Model with 3-cycle propagation delay, SETTLE_CYCLES=2 -> mismatches counted; SETTLE_CYCLES=6 -> pass=1.
REQ-038 rst asserted during SETTLE of vector 10 -> next cycle IDLE, drive pins 0, no done; new start runs full 24 cycles.
REQ-039 start pulsed every cycle during a run, truth toggled mid-run -> single run, result uses truth latched at start.
